// File: rtl/pc_gen_pkg.sv
// Shared fetch-path constants for the program-counter generator.
// Replaces the old defines.vh macros with typed package constants.
package pc_gen_pkg;
    localparam logic        RST_ENABLE   = 1'b0;
    localparam logic        BRANCH       = 1'b1;
    localparam int          INST_ADDR_W  = 32;
    localparam logic [31:0] PC_INIT_ADDR = 32'h8000_0000;
endpackage

// File: rtl/pc_gen_if.sv
// Control/branch request bundle into the PC generator and its fetch-side outputs.
// The master drives requests (CTRL/ID); the slave is pc_gen itself.
interface pc_gen_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              stall_if;
    logic              load_store_rom_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic [ADDR_W-1:0] pc_o;
    logic              load_store_rom_o;
    logic              misalign_o;
    logic [CNT_W-1:0]  hold_cnt_o;

    modport master (
        output flush, new_pc, stall_if, load_store_rom_i, branch_flag_i, branch_target_i,
        input  pc_o, load_store_rom_o, misalign_o, hold_cnt_o
    );

    modport slave (
        input  flush, new_pc, stall_if, load_store_rom_i, branch_flag_i, branch_target_i,
        output pc_o, load_store_rom_o, misalign_o, hold_cnt_o
    );
endinterface

// File: rtl/pc_gen_pend_latch.sv
// Holds a branch that arrived while fetch was held so it can be applied on release.
// Clear wins over set; a new set always overwrites the stored target.
import pc_gen_pkg::*;

module pc_pend_latch #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_tgt,
    output logic              o_pend_vld,
    output logic [ADDR_W-1:0] o_pend_tgt
);
    logic              r_vld;
    logic [ADDR_W-1:0] r_tgt;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_vld <= 1'b0;
            r_tgt <= '0;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end else if (i_set) begin
            r_vld <= 1'b1;
            r_tgt <= i_tgt;
        end
    end

    assign o_pend_vld = r_vld;
    assign o_pend_tgt = r_tgt;
endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: reset vector, flush redirect, branch (live or pending) or increment.
// Also flags misaligned redirect targets and counts held cycles.
import pc_gen_pkg::*;

module pc_gen #(
    parameter int                ADDR_W     = INST_ADDR_W,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_INIT_ADDR),
    parameter int                CNT_W      = 16
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam int                LSB      = $clog2(INST_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << LSB) - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] r_pc;
    logic              r_ls_rom;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_hold_cnt;

    logic              w_hold;
    logic              w_live_branch;
    logic              w_load;
    logic [ADDR_W-1:0] w_target;
    logic              w_pend_vld;
    logic [ADDR_W-1:0] w_pend_tgt;
    logic              w_pend_set;
    logic              w_pend_clr;

    assign w_hold        = bus.stall_if | bus.load_store_rom_i;
    assign w_live_branch = (bus.branch_flag_i == BRANCH);

    // A flush or any redirect consumed while not held retires the pending branch.
    assign w_load     = bus.flush | (~w_hold & (w_live_branch | w_pend_vld));
    assign w_pend_set = ~bus.flush & w_hold & w_live_branch;
    assign w_pend_clr = w_load;

    always_comb begin
        w_target = w_pend_tgt;
        if (bus.flush) begin
            w_target = bus.new_pc;
        end else if (w_live_branch) begin
            w_target = bus.branch_target_i;
        end
    end

    pc_pend_latch #(.ADDR_W(ADDR_W)) u_pend (
        .clk        (clk),
        .rst        (rst),
        .i_set      (w_pend_set),
        .i_clr      (w_pend_clr),
        .i_tgt      (bus.branch_target_i),
        .o_pend_vld (w_pend_vld),
        .o_pend_tgt (w_pend_tgt)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_pc       <= RESET_ADDR;
            r_ls_rom   <= 1'b0;
            r_misalign <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_ls_rom   <= bus.load_store_rom_i;
            r_misalign <= w_load & (|(w_target & LOW_MASK));
            if (w_load) begin
                r_pc <= w_target & ~LOW_MASK;
            end else if (!w_hold) begin
                r_pc <= r_pc + STEP;
            end
            if (w_hold && (r_hold_cnt != '1)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_o             = r_pc;
    assign bus.load_store_rom_o = r_ls_rom;
    assign bus.misalign_o       = r_misalign;
    assign bus.hold_cnt_o       = r_hold_cnt;
endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen with hand-computed expectations.
// CNT_W is narrowed to 4 so counter saturation is reachable in a few cycles.
module tb_pc_gen;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

    pc_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pc_gen #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (4),
        .RESET_ADDR (32'h8000_0000),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge; inputs are changed only here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fl, input logic [31:0] npc, input logic st,
                                 input logic lsr, input logic br, input logic [31:0] tgt);
        bus.flush            = fl;
        bus.new_pc           = npc;
        bus.stall_if         = st;
        bus.load_store_rom_i = lsr;
        bus.branch_flag_i    = br;
        bus.branch_target_i  = tgt;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b0;
        idle();
        tick();
        tick();
        checkOutput("reset_pc", bus.pc_o, 32'h8000_0000);
        checkOutput("reset_lsro", bus.load_store_rom_o, 1'b0);
        checkOutput("reset_mis", bus.misalign_o, 1'b0);
        checkOutput("reset_cnt", bus.hold_cnt_o, 4'd0);

        rst = 1'b1;
        tick(); checkOutput("seq_1", bus.pc_o, 32'h8000_0004);
        tick(); checkOutput("seq_2", bus.pc_o, 32'h8000_0008);
        tick(); checkOutput("seq_3", bus.pc_o, 32'h8000_000C);

        // Stall 3 cycles, branch in the 2nd, release with no branch.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(); checkOutput("stall_hold_1", bus.pc_o, 32'h8000_000C);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_1000);
        tick(); checkOutput("stall_hold_2", bus.pc_o, 32'h8000_000C);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(); checkOutput("stall_hold_3", bus.pc_o, 32'h8000_000C);
        idle();
        tick();
        checkOutput("pend_applied", bus.pc_o, 32'h0000_1000);
        checkOutput("hold_cnt_3", bus.hold_cnt_o, 4'd3);
        tick(); checkOutput("after_pend", bus.pc_o, 32'h0000_1004);

        // Same, but a live branch arrives on release and beats the pending one.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_1000);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_2000);
        tick(); checkOutput("live_beats_pend", bus.pc_o, 32'h0000_2000);
        idle();
        tick(); checkOutput("pend_dropped", bus.pc_o, 32'h0000_2004);
        checkOutput("hold_cnt_6", bus.hold_cnt_o, 4'd6);

        // Flush during ROM conflict with a pending branch.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_3000);
        tick(); checkOutput("pend_set_hold", bus.pc_o, 32'h0000_2004);
        applyStimulus(1'b1, 32'h0000_0180, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("flush_pc", bus.pc_o, 32'h0000_0180);
        checkOutput("flush_lsro", bus.load_store_rom_o, 1'b1);
        idle();
        tick();
        checkOutput("flush_cleared_pend", bus.pc_o, 32'h0000_0184);
        checkOutput("lsro_drop", bus.load_store_rom_o, 1'b0);

        // Misaligned branch and flush targets.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_1002);
        tick();
        checkOutput("mis_br_pc", bus.pc_o, 32'h0000_1000);
        checkOutput("mis_br_flag", bus.misalign_o, 1'b1);
        idle();
        tick();
        checkOutput("mis_br_next", bus.pc_o, 32'h0000_1004);
        checkOutput("mis_br_clear", bus.misalign_o, 1'b0);
        applyStimulus(1'b1, 32'h0000_0203, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("mis_fl_pc", bus.pc_o, 32'h0000_0200);
        checkOutput("mis_fl_flag", bus.misalign_o, 1'b1);
        idle();
        tick(); checkOutput("mis_fl_clear", bus.misalign_o, 1'b0);

        // Latest pending branch wins.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_4000);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_4400);
        tick(); checkOutput("latest_hold", bus.pc_o, 32'h0000_0204);
        idle();
        tick(); checkOutput("latest_wins", bus.pc_o, 32'h0000_4400);

        // Address wrap-around.
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); checkOutput("wrap_f8", bus.pc_o, 32'hFFFF_FFF8);
        idle();
        tick(); checkOutput("wrap_fc", bus.pc_o, 32'hFFFF_FFFC);
        tick(); checkOutput("wrap_0", bus.pc_o, 32'h0000_0000);
        tick(); checkOutput("wrap_4", bus.pc_o, 32'h0000_0004);

        // Counter saturation: 2^CNT_W + 5 held cycles after a fresh reset.
        rst = 1'b0;
        tick(); checkOutput("cnt_reset", bus.hold_cnt_o, 4'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("cnt_14", bus.hold_cnt_o, 4'd14);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("cnt_sat", bus.hold_cnt_o, 4'd15);
        checkOutput("stall_pc_reset", bus.pc_o, 32'h8000_0000);

        // Reset mid-stall with a pending branch and a concurrent flush request.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_5000);
        tick();
        applyStimulus(1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("rst_mid_pc", bus.pc_o, 32'h8000_0000);
        checkOutput("rst_mid_cnt", bus.hold_cnt_o, 4'd0);
        rst = 1'b1;
        idle();
        tick(); checkOutput("rst_pend_gone", bus.pc_o, 32'h8000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
